// File: rtl/pulse_out_arb.sv
// pulse_out_arb
// Collects signed samples from a pulse simulator on two channels (truth and
// readout), buffers each channel in its own FIFO and merges them onto a single
// valid/ready output with round-robin arbitration.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous reset, active low
//   in_en      write strobes: bit 0 truth channel, bit 1 readout channel
//   in_data    signed sample shared by both channels
//   out_valid  out_data/out_ch hold a word
//   out_ready  consumer accepts the word when high together with out_valid
//   out_data   granted sample
//   out_ch     channel of out_data (0 = truth, 1 = readout)
//   ovf        sticky per-channel overflow flags
//   clr_ovf    synchronous clear of ovf (and of the drop counters)
//   drop0/1    16-bit saturating drop counters, only when
//              PULSE_ARB_DROPCNT_EN is defined
//
// Output stage states
//   S_EMPTY | no word held, out_valid = 0
//   S_FULL  | word held in out_data/out_ch, out_valid = 1
module pulse_out_arb #(
  parameter int DW    = 23,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           in_en,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_ch,
  output logic [1:0]           ovf,
  input  logic                 clr_ovf
`ifdef PULSE_ARB_DROPCNT_EN
  ,
  output logic [15:0]          drop0,
  output logic [15:0]          drop1
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t             state;
  logic               last;
  logic [DW-1:0]      mem [2][DEPTH];
  logic [AW-1:0]      wr_ptr [2];
  logic [AW-1:0]      rd_ptr [2];
  logic [AW:0]        cnt [2];

  logic [1:0]         nonempty;
  logic [1:0]         full;
  logic [1:0]         pop;
  logic [1:0]         push_ok;
  logic [1:0]         drop;
  logic               grant;
  logic               pop_any;
  logic [DW-1:0]      head;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      nonempty[k] = (cnt[k] != '0);
      full[k]     = (cnt[k] == FULL_CNT);
    end
    // Tie goes to the channel not granted last; otherwise the lone non-empty
    // channel wins (nonempty[1] is 1 exactly when only readout has data).
    grant   = (&nonempty) ? ~last : nonempty[1];
    pop_any = ((state == S_EMPTY) || out_ready) && (|nonempty);
    pop[0]  = pop_any && !grant;
    pop[1]  = pop_any && grant;
    for (int k = 0; k < 2; k++) begin
      // A pop from a full FIFO frees the slot at the same edge.
      push_ok[k] = in_en[k] && (!full[k] || pop[k]);
      drop[k]    = in_en[k] && full[k] && !pop[k];
    end
    head = mem[grant][rd_ptr[grant]];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push_ok[k]) mem[k][wr_ptr[k]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push_ok[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])     rd_ptr[k] <= rd_ptr[k] + 1'b1;
        cnt[k] <= cnt[k] + {{AW{1'b0}}, push_ok[k]} - {{AW{1'b0}}, pop[k]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~{2{clr_ovf}}) | drop;
    end
  end

`ifdef PULSE_ARB_DROPCNT_EN
  logic [15:0] drop_cnt [2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt[0] <= '0;
      drop_cnt[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (clr_ovf)
          drop_cnt[k] <= {15'd0, drop[k]};
        else if (drop[k] && (drop_cnt[k] != 16'hFFFF))
          drop_cnt[k] <= drop_cnt[k] + 16'd1;
      end
    end
  end

  assign drop0 = drop_cnt[0];
  assign drop1 = drop_cnt[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= 1'b0;
      last      <= 1'b1;
    end else begin
      if (pop_any) begin
        out_data <= head;
        out_ch   <= grant;
        last     <= grant;
      end
      case (state)
        S_EMPTY: begin
          if (pop_any) begin
            state     <= S_FULL;
            out_valid <= 1'b1;
          end
        end
        S_FULL: begin
          if (out_ready && !pop_any) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
